dmem_arbiter: RTL

Two-port arbiter and sequencer for the 1024 x 16-bit data memory. The arbiter shares one memory port between two requesters: port 0 is the CPU load/store unit and port 1 is the DMA/debug loader. It grants them round-robin, drives the memory's address, data, read-enable and write-enable lines, and returns read data and a one-cycle acknowledge to the granted port. It sits between the pipeline MEM stage, the loader and the data memory instance.

---
 rtl/dmem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the single-ported data memory.
// Serializes port 0 (LSU) and port 1 (loader) accesses through IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writedata,
    output logic          mem_memread,
    output logic          mem_memwrite,
    input  logic [DW-1:0] mem_readdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          elig0, elig1, win;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        ack0 = (state_q == RESP) && !gnt_q;
        ack1 = (state_q == RESP) &&  gnt_q;

        // The port being acked still holds req this cycle; don't regrant it.
        elig0 = req0 && !ack0;
        elig1 = req1 && !ack1;
        win   = (elig0 && elig1) ? ~last_q : elig1;

        case (state_q)
            IDLE, RESP: begin
                if (elig0 || elig1) begin
                    state_d = ACCESS;
                    gnt_d   = win;
                    last_d  = win;
                    cmd_d   = win ? '{we: we1, addr: addr1, wdata: wdata1}
                                  : '{we: we0, addr: addr0, wdata: wdata0};
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!cmd_q.we) begin
                    if (gnt_q) rdata1_d = mem_readdata;
                    else       rdata0_d = mem_readdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Reset gate keeps an in-flight write from committing during an abort.
    assign mem_address   = cmd_q.addr;
    assign mem_writedata = cmd_q.wdata;
    assign mem_memread   = (state_q == ACCESS) && !cmd_q.we;
    assign mem_memwrite  = (state_q == ACCESS) &&  cmd_q.we && !reset;
    assign busy          = (state_q == ACCESS) || (state_q == RESP);
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;

endmodule
